// File: rtl/full_hash_des_if.sv
// Byte-stream source to hash engine bundle: message byte, length and digest return.
// No latency of its own; a plain wire bundle.
// No backpressure signal; the source must pace itself around finalization.
interface full_hash_des_if #(
   parameter int LEN_W = 64
);
   logic             M_valid;
   logic [LEN_W-1:0] C_in;
   logic [7:0]       M;
   logic             hash_ready;
   logic [31:0]      digest;

   // Byte source side
   modport master (
      output M_valid,
      output C_in,
      output M,
      input  hash_ready,
      input  digest
   );

   // Hash engine side
   modport slave (
      input  M_valid,
      input  C_in,
      input  M,
      output hash_ready,
      output digest
   );
endinterface

// File: rtl/full_hash_des.sv
// Streaming 32-bit hash on the DES S1 S-box: one byte per cycle, then 8 length bytes.
// Latency: last message byte at edge T, hash_ready/digest update at edge T+9.
// No backpressure: bytes presented during finalization or done are dropped.
module full_hash_des #(
   parameter int ROUNDS = 4,
   parameter int LEN_W  = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   full_hash_des_if.slave       bus
);

   typedef enum logic [1:0] {
      IDLE,
      ABSORB,
      FINAL,
      DONE
   } state_t;

   // Initial chaining value {H7..H0}
   localparam logic [31:0] H_INIT = 32'h30FD_17B4;

   // S1 rows, nibble c holds column c
   localparam logic [63:0] S1_R0 = 64'h7095_C6A3_8BF2_1D4E;
   localparam logic [63:0] S1_R1 = 64'h8359_BC6A_1D2E_47F0;
   localparam logic [63:0] S1_R2 = 64'h05A3_79CF_B26D_8E14;
   localparam logic [63:0] S1_R3 = 64'hD60A_E3B5_7194_28CF;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len, len_nxt;
   logic [LEN_W-1:0] cnt, cnt_nxt;
   logic [31:0]      h, h_nxt;
   logic [2:0]       k, k_nxt;
   logic [31:0]      dig_q, dig_nxt;
   logic             hr_q, hr_nxt;

   function automatic logic [5:0] byte_tf(input logic [7:0] m);
      return {m[7] ^ m[1], m[3], m[2], m[5] ^ m[0], m[4], m[6]};
   endfunction

   function automatic logic [3:0] sbox(input logic [5:0] x);
      logic [63:0] row;
      case ({x[5], x[0]})
         2'b00:   row = S1_R0;
         2'b01:   row = S1_R1;
         2'b10:   row = S1_R2;
         default: row = S1_R3;
      endcase
      return row[{x[4:1], 2'b00} +: 4];
   endfunction

   // Every nibble takes its upper neighbour xor S, rotated left by i/2
   function automatic logic [31:0] one_round(input logic [31:0] hv, input logic [3:0] s);
      logic [31:0] r;
      logic [3:0]  t;
      logic [7:0]  tt;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         t  = hv[((i + 1) % 8) * 4 +: 4] ^ s;
         tt = {t, t} << (i / 2);
         r[i * 4 +: 4] = tt[7:4];
      end
      return r;
   endfunction

   // S depends only on the byte, so it is shared across the unrolled rounds
   function automatic logic [31:0] absorb(input logic [31:0] hv, input logic [7:0] m);
      logic [31:0] acc;
      logic [3:0]  s;
      s   = sbox(byte_tf(m));
      acc = hv;
      for (int r = 0; r < ROUNDS; r++) begin
         acc = one_round(acc, s);
      end
      return acc;
   endfunction

   // State and datapath registers, synchronous reset wins over everything
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state <= IDLE;
         len   <= '0;
         cnt   <= '0;
         h     <= H_INIT;
         k     <= '0;
         dig_q <= '0;
         hr_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         len   <= len_nxt;
         cnt   <= cnt_nxt;
         h     <= h_nxt;
         k     <= k_nxt;
         dig_q <= dig_nxt;
         hr_q  <= hr_nxt;
      end
   end

   // Next-state and datapath update for absorb, length finalization and digest publish
   always_comb begin
      state_nxt = state;
      len_nxt   = len;
      cnt_nxt   = cnt;
      h_nxt     = h;
      k_nxt     = k;
      dig_nxt   = dig_q;
      hr_nxt    = 1'b0;
      case (state)
         IDLE: begin
            // A zero-length message cannot start; its byte is dropped
            if (bus.M_valid && (bus.C_in != '0)) begin
               len_nxt   = bus.C_in;
               h_nxt     = absorb(H_INIT, bus.M);
               cnt_nxt   = LEN_W'(1);
               k_nxt     = '0;
               state_nxt = (bus.C_in == LEN_W'(1)) ? FINAL : ABSORB;
            end
         end
         ABSORB: begin
            if (bus.M_valid) begin
               h_nxt   = absorb(h, bus.M);
               cnt_nxt = cnt + LEN_W'(1);
               if (cnt_nxt == len) begin
                  k_nxt     = '0;
                  state_nxt = FINAL;
               end
            end
         end
         FINAL: begin
            // Length bytes, least significant first
            h_nxt = absorb(h, len[{k, 3'b000} +: 8]);
            k_nxt = k + 3'd1;
            if (k == 3'd7) begin
               state_nxt = DONE;
            end
         end
         default: begin
            dig_nxt   = h;
            hr_nxt    = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.hash_ready = hr_q;
   assign bus.digest     = dig_q;

endmodule

// File: tb/tb_full_hash_des.sv
// Scoreboard bench for full_hash_des: randomized byte streams against an arithmetic model.
// Expected digest and pulse cycle are queued at stimulus time and checked by a monitor.
// The driver respects the no-backpressure rule and sprays junk during finalization.
module tb_full_hash_des;

   typedef struct {
      logic [31:0] dig;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_fail;

   exp_t        expq[$];
   logic [31:0] got[$];

   int SB[4][16] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7},
      '{ 0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8},
      '{ 4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0},
      '{15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13}
   };

   full_hash_des_if #(.LEN_W(64)) bus ();

   full_hash_des #(.ROUNDS(4), .LEN_W(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int bitv(input int v, input int n);
      return (v >> n) & 1;
   endfunction

   function automatic int m_sbox(input int x);
      return SB[bitv(x, 5) * 2 + bitv(x, 0)][(x >> 1) & 15];
   endfunction

   function automatic int m_tf(input int m);
      return (bitv(m, 7) ^ bitv(m, 1)) * 32 + bitv(m, 3) * 16 + bitv(m, 2) * 8
           + (bitv(m, 5) ^ bitv(m, 0)) * 4 + bitv(m, 4) * 2 + bitv(m, 6);
   endfunction

   function automatic int rotl4(input int v, input int r);
      return ((v << r) | (v >> (4 - r))) & 15;
   endfunction

   function automatic logic [31:0] model_digest(input logic [7:0] b[64], input int n);
      int          h[8];
      int          nh[8];
      int          seq[$];
      int          s;
      longint      ln;
      logic [31:0] d;
      h  = '{4, 11, 7, 1, 13, 15, 0, 3};
      ln = longint'(n);
      for (int i = 0; i < n; i++) seq.push_back(int'(b[i]));
      for (int j = 0; j < 8; j++) seq.push_back(int'((ln >> (8 * j)) & 255));
      foreach (seq[q]) begin
         s = m_sbox(m_tf(seq[q]));
         for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) nh[i] = rotl4(h[(i + 1) % 8] ^ s, i / 2);
            h = nh;
         end
      end
      d = '0;
      for (int i = 0; i < 8; i++) d = d | (32'(h[i]) << (4 * i));
      return d;
   endfunction

   // ---------------- driver ----------------
   task automatic drive_idle();
      @(negedge clk);
      bus.M_valid = 1'b0;
      bus.M       = 8'($urandom);
      bus.C_in    = {$urandom, $urandom};
   endtask

   // abort_at >= 0 stops after that many bytes and queues nothing
   task automatic send_msg(input int n, input int start, input int step, input int gap_pct,
                           input bit rnd, input bit junk, input int abort_at);
      logic [7:0] b[64];
      int         last_edge;
      exp_t       e;
      last_edge = 0;
      for (int i = 0; i < 64; i++) b[i] = rnd ? 8'($urandom) : 8'(start + i * step);
      for (int i = 0; i < n; i++) begin
         if (abort_at >= 0 && i == abort_at) return;
         while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) drive_idle();
         @(negedge clk);
         bus.M_valid = 1'b1;
         bus.M       = b[i];
         bus.C_in    = (i == 0) ? 64'(n) : {$urandom, $urandom};
         last_edge   = cyc + 1;
      end
      e.dig = model_digest(b, n);
      e.cyc = last_edge + 9;
      expq.push_back(e);
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         bus.M_valid = junk ? 1'($urandom_range(1)) : 1'b0;
         bus.M       = 8'($urandom);
         bus.C_in    = {$urandom, $urandom};
      end
      drive_idle();
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (expq.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", expq.size() == 0, 64'(expq.size()), 64'd0);
   endtask

   // ---------------- monitor ----------------
   logic [31:0] last_dig;
   bit          prev_hr;
   exp_t        me;

   // Pops the scoreboard on each pulse and checks width, timing and hold behaviour
   always @(negedge clk) begin
      if (rst_n) begin
         last_dig = '0;
         prev_hr  = 1'b0;
      end else begin
         if (bus.hash_ready) begin
            chk("pulse_width", !prev_hr, 64'(prev_hr), 64'd0);
            if (expq.size() == 0) begin
               chk("unexpected_pulse", 1'b0, 64'(bus.digest), 64'd0);
            end else begin
               me = expq.pop_front();
               chk("digest", bus.digest === me.dig, 64'(bus.digest), 64'(me.dig));
               chk("pulse_cycle", cyc == me.cyc, 64'(cyc), 64'(me.cyc));
            end
            got.push_back(bus.digest);
         end else begin
            chk("digest_hold", bus.digest === last_dig, 64'(bus.digest), 64'(last_dig));
         end
         last_dig = bus.digest;
         prev_hr  = bus.hash_ready;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      cyc         = 0;
      n_chk       = 0;
      n_fail      = 0;
      rst_n       = 1'b1;
      bus.M_valid = 1'b0;
      bus.M       = '0;
      bus.C_in    = '0;

      // reset held 3 cycles
      repeat (3) @(negedge clk);
      chk("reset_hash_ready", bus.hash_ready === 1'b0, 64'(bus.hash_ready), 64'd0);
      chk("reset_digest", bus.digest === 32'h0, 64'(bus.digest), 64'd0);
      rst_n = 1'b0;
      drive_idle();

      // 26 contiguous bytes, twice
      send_msg(26, 0, 1, 0, 1'b0, 1'b0, -1);
      send_msg(26, 0, 1, 0, 1'b0, 1'b0, -1);
      // 25 bytes
      send_msg(25, 0, 1, 0, 1'b0, 1'b0, -1);
      // 10 even bytes, contiguous then with gaps
      send_msg(10, 0, 2, 0, 1'b0, 1'b0, -1);
      send_msg(10, 0, 2, 50, 1'b0, 1'b0, -1);
      // single zero byte, clean then with junk during finalization
      send_msg(1, 0, 0, 0, 1'b0, 1'b0, -1);
      send_msg(1, 0, 0, 0, 1'b0, 1'b1, -1);
      wait_drain();

      // zero-length start attempts are dropped
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.M_valid = 1'b1;
         bus.M       = 8'($urandom);
         bus.C_in    = '0;
      end
      drive_idle();

      // reset mid-absorb, then a clean 26-byte message
      send_msg(12, 0, 1, 0, 1'b0, 1'b0, 5);
      @(negedge clk);
      rst_n       = 1'b1;
      bus.M_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("midreset_hash_ready", bus.hash_ready === 1'b0, 64'(bus.hash_ready), 64'd0);
      chk("midreset_digest", bus.digest === 32'h0, 64'(bus.digest), 64'd0);
      rst_n = 1'b0;
      drive_idle();
      send_msg(26, 0, 1, 0, 1'b0, 1'b0, -1);
      wait_drain();

      if (got.size() >= 8) begin
         chk("rerun_same", got[1] === got[0], 64'(got[1]), 64'(got[0]));
         chk("length_sensitive", got[2] !== got[0], 64'(got[2]), 64'(got[0]));
         chk("gaps_equal", got[4] === got[3], 64'(got[4]), 64'(got[3]));
         chk("final_junk_ignored", got[6] === got[5], 64'(got[6]), 64'(got[5]));
         chk("after_reset_clean", got[7] === got[0], 64'(got[7]), 64'(got[0]));
      end else begin
         chk("pulse_count", 1'b0, 64'(got.size()), 64'd8);
      end

      // randomized messages with gaps, junk and occasional zero-length attempts
      for (int m = 0; m < 14; m++) begin
         if ($urandom_range(3) == 0) begin
            @(negedge clk);
            bus.M_valid = 1'b1;
            bus.M       = 8'($urandom);
            bus.C_in    = '0;
            drive_idle();
         end
         send_msg(int'($urandom_range(20, 1)), 0, 0, int'($urandom_range(40)), 1'b1, 1'b1, -1);
      end
      wait_drain();
      repeat (3) drive_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
